// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and grant identifiers for the memory-port arbiter.
// Revision 1.0
`default_nettype none

package mem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_ISSUE = ISSUE,
    ST_WAIT  = WAIT,
    ST_DONE  = DONE
  } state_t;

  // Under contention the requester that was not served last time wins.
  function automatic logic other_grant(input logic g);
    return (g == GRANT_A) ? GRANT_B : GRANT_A;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
// Revision 1.0
`default_nettype none

module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  always_comb begin
    grant = GRANT_A;
    valid = req_a | req_b;
    if (req_a && req_b) begin
      grant = other_grant(last_grant);
    end else if (req_b) begin
      grant = GRANT_B;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous single-port memory between requesters A and B,
// sequencing each access as ISSUE/WAIT/DONE with registered outputs. Revision 1.0
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy,
  output logic              mem_cs,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t            state;
  logic              last_grant;
  logic              winner;
  logic              pick_grant;
  logic              pick_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_pick (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  always_comb begin
    sel_we    = we_a;
    sel_addr  = addr_a;
    sel_wdata = wdata_a;
    if (pick_grant == GRANT_B) begin
      sel_we    = we_b;
      sel_addr  = addr_b;
      sel_wdata = wdata_b;
    end
  end

  // mem_adr/mem_din double as the latched request; they stay put until the next IDLE sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_B;
      winner     <= GRANT_A;
      mem_cs     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_adr    <= '0;
      mem_din    <= '0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      rdata_a    <= '0;
      rdata_b    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          if (pick_valid) begin
            winner     <= pick_grant;
            last_grant <= pick_grant;
            mem_cs     <= 1'b1;
            mem_wr     <= sel_we;
            mem_adr    <= sel_addr;
            mem_din    <= sel_wdata;
            busy       <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_wr <= 1'b0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // Memory output now reflects the op done at the ISSUE edge (read-back for writes).
          mem_cs <= 1'b0;
          mem_wr <= 1'b0;
          if (winner == GRANT_A) begin
            rdata_a <= mem_dout;
            ack_a   <= 1'b1;
          end else begin
            rdata_b <= mem_dout;
            ack_b   <= 1'b1;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_one_ack : assert property (@(posedge clock) disable iff (!reset_n) !(ack_a && ack_b));
  a_wr_issue : assert property (@(posedge clock) disable iff (!reset_n) mem_wr |-> (state == ST_ISSUE));
`endif

endmodule

`default_nettype wire
